sram_access_ctrl: RTL and testbench
===================================

SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 The block SHALL have parameter T_PRE, default 2, precharge duration in cycles, legal range 1..15.
REQ-002 The block SHALL have parameter T_WL, default 2, wordline-active duration in cycles before sense or write end, legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes occur on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  1  access request.
REQ-006 we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 addr  input  4  row address, 16 rows.
REQ-008 wdata  input  8  write data.
REQ-009 sense_in  input  8  digitised sense-amplifier outputs.
REQ-010 ready  output  1  controller idle, request may be accepted.
REQ-011 rvalid  output  1  one-cycle read-data-valid strobe.
REQ-012 rdata  output  8  read data.
REQ-013 pre_en  output  1  bitline precharge enable.
REQ-014 bl_pre_v  output  real  precharge drive level: VDD (1.5) when pre_en=1, else VSS (0.0).
REQ-015 wl_en  output  16  one-hot wordline enables.
REQ-016 sae  output  1  sense-amplifier enable.
REQ-017 wd_en  output  1  write-driver enable.
REQ-018 bl_data  output  8  write-driver data.

Function
REQ-019 The FSM SHALL have states IDLE, PRECHARGE, WL_ON, SENSE, WRITE, RECOVER.
REQ-020 ready SHALL be 1 only in IDLE; a request is accepted on an edge where req=1 and ready=1, latching addr, we and wdata.
REQ-021 req in any state other than IDLE SHALL be ignored; no request is queued.
REQ-022 After acceptance, PRECHARGE SHALL hold pre_en=1 for exactly T_PRE cycles.
REQ-023 Read path: PRECHARGE -> WL_ON (T_WL cycles) -> SENSE (1 cycle) -> RECOVER (1 cycle) -> IDLE.
REQ-024 Write path: PRECHARGE -> WRITE (T_WL cycles) -> RECOVER (1 cycle) -> IDLE.
REQ-025 wl_en[addr_latched] SHALL be 1 in WL_ON, SENSE and WRITE; all other wl_en bits SHALL be 0 at all times.
REQ-026 sae SHALL be 1 only in SENSE; on the edge leaving SENSE, sense_in SHALL be captured into rdata.
REQ-027 rvalid SHALL be 1 for exactly the RECOVER cycle of a read; rdata SHALL hold its value until the next read capture.
REQ-028 wd_en SHALL be 1 only in WRITE, with bl_data equal to the latched wdata; bl_data SHALL be 0 outside WRITE.
REQ-029 pre_en and any wl_en bit SHALL never be 1 in the same cycle; sae and wd_en SHALL never be 1 together.
REQ-030 In RECOVER, pre_en, wl_en, sae and wd_en SHALL all be 0.
REQ-031 With the default parameters, read latency from the accept edge to rvalid SHALL be 6 cycles, and ready SHALL return at cycle 7. For a write, ready SHALL return at cycle 6.
REQ-032 Internal cycle counters SHALL be 4 bits wide and SHALL reload on every state entry; they SHALL never wrap within a state.

Reset
REQ-033 While rst=1, the FSM SHALL be in IDLE and outputs SHALL be: ready=1, rvalid=0, rdata=0, pre_en=0, bl_pre_v=0.0, wl_en=0, sae=0, wd_en=0, bl_data=0.
REQ-034 Reset asserted mid-access SHALL abort the access immediately with no rvalid; the first accept after reset release occurs no earlier than the first edge with rst=0.

Structure
REQ-035 The state enum and constants VDD=1.5, VSS=0.0 and VTH=0.8 SHALL live in shared package sram_pkg.
REQ-036 The 4-to-16 one-hot decode SHALL be a sub-module, sram_row_decoder, with an enable input.

Verification
REQ-037 Reset, then read addr=5 with sense_in=8'hA5 -> pre_en high in cycles 1-2, wl_en=16'h0020 in cycles 3-5, sae in cycle 5, rvalid with rdata=8'hA5 in cycle 6, ready in cycle 7.
REQ-038 Write addr=15, wdata=8'h3C -> wl_en=16'h8000 and wd_en=1 with bl_data=8'h3C in cycles 3-4; ready in cycle 6; no rvalid.
REQ-039 req held high continuously -> the second access is accepted only when ready=1 and is not accepted during RECOVER.
REQ-040 rst pulse during WL_ON -> all outputs take reset values within the same cycle; no rvalid occurs.
REQ-041 T_PRE=1, T_WL=1 -> read rvalid at cycle 4; assertions for REQ-025 and REQ-029 hold throughout.
REQ-042 bl_pre_v tracks pre_en: 1.5 while precharging, 0.0 otherwise.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM access controller.
//   sram_state_e : controller FSM states
//   VDD/VSS/VTH  : analogue levels used for bitline drive modelling
//   CNT_W        : width of the dwell counters
package sram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRECHARGE,
    WL_ON,
    SENSE,
    WRITE,
    RECOVER
  } sram_state_e;

  localparam real VDD = 1.5;
  localparam real VSS = 0.0;
  localparam real VTH = 0.8;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/sram_row_decoder.sv
// 4-to-16 one-hot row decoder with enable.
//   en    : when 0 all wordlines are low
//   addr  : row address
//   wl_en : one-hot wordline enables (all zero when en=0)
module sram_row_decoder (
  input  logic        en,
  input  logic [3:0]  addr,
  output logic [15:0] wl_en
);

  always_comb begin
    wl_en = '0;
    if (en) begin
      wl_en[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/sram_access_ctrl.sv
// Single-port SRAM access sequencer.
// Accepts one read or write request at a time while idle, then sequences
// bitline precharge, wordline activation, sensing or write drive, and a
// recovery cycle before returning to idle.
//   clk, rst     : clock, asynchronous active-high reset
//   req/we       : request strobe and direction (1 = write), sampled when ready
//   addr, wdata  : row address and write data, latched on accept
//   sense_in     : digitised sense-amp outputs, captured leaving SENSE
//   ready        : idle, request may be accepted
//   rvalid/rdata : one-cycle read strobe and held read data
//   pre_en       : bitline precharge enable, bl_pre_v its drive level
//   wl_en        : one-hot wordline enables
//   sae, wd_en   : sense-amp enable, write-driver enable
//   bl_data      : write-driver data (zero outside WRITE)
module sram_access_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned T_PRE = 2,
  parameter int unsigned T_WL  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [7:0]  wdata,
  input  logic [7:0]  sense_in,
  output logic        ready,
  output logic        rvalid,
  output logic [7:0]  rdata,
  output logic        pre_en,
  output real         bl_pre_v,
  output logic [15:0] wl_en,
  output logic        sae,
  output logic        wd_en,
  output logic [7:0]  bl_data
);

  sram_state_e      state_q;
  sram_state_e      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_done;
  logic             accept;
  logic             wl_active;

  logic [3:0]       addr_q;
  logic             we_q;
  logic [7:0]       wdata_q;
  logic [7:0]       rdata_q;

  // Dwell counter is loaded with (cycles - 1) on entry so that zero marks the
  // final cycle of the state; single-cycle states load zero.
  function automatic logic [CNT_W-1:0] dwell_load(sram_state_e s);
    case (s)
      PRECHARGE:     return CNT_W'(T_PRE - 1);
      WL_ON, WRITE:  return CNT_W'(T_WL - 1);
      default:       return '0;
    endcase
  endfunction

  assign cnt_done = (cnt_q == '0);
  assign accept   = (state_q == IDLE) && req;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (req) state_d = PRECHARGE;
      PRECHARGE: if (cnt_done) state_d = we_q ? WRITE : WL_ON;
      WL_ON:     if (cnt_done) state_d = SENSE;
      SENSE:     state_d = RECOVER;
      WRITE:     if (cnt_done) state_d = RECOVER;
      RECOVER:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    ready     = 1'b0;
    rvalid    = 1'b0;
    pre_en    = 1'b0;
    wl_active = 1'b0;
    sae       = 1'b0;
    wd_en     = 1'b0;
    bl_data   = '0;
    case (state_q)
      IDLE:      ready = 1'b1;
      PRECHARGE: pre_en = 1'b1;
      WL_ON:     wl_active = 1'b1;
      SENSE: begin
        wl_active = 1'b1;
        sae       = 1'b1;
      end
      WRITE: begin
        wl_active = 1'b1;
        wd_en     = 1'b1;
        bl_data   = wdata_q;
      end
      RECOVER:   rvalid = ~we_q;
      default:   ready = 1'b0;
    endcase
  end

  // Reloads on every state change and saturates at zero, so it cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= dwell_load(state_d);
    end else if (!cnt_done) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Request capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= addr;
      we_q    <= we;
      wdata_q <= wdata;
    end
  end

  // SENSE always lasts one cycle, so sampling in SENSE is the capture on the
  // edge leaving it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (state_q == SENSE) begin
      rdata_q <= sense_in;
    end
  end

  assign rdata    = rdata_q;
  assign bl_pre_v = pre_en ? VDD : VSS;

  sram_row_decoder u_row_dec (
    .en    (wl_active),
    .addr  (addr_q),
    .wl_en (wl_en)
  );

endmodule

// File: tb/tb_sram_access_ctrl.sv
module tb_sram_access_ctrl;

  localparam int TPA [2] = '{2, 1};
  localparam int TWA [2] = '{2, 1};

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [3:0]  addr;
  logic [7:0]  wdata;
  logic [7:0]  sense_in;

  logic        ready0, rvalid0, pre_en0, sae0, wd_en0;
  logic [7:0]  rdata0, bl_data0;
  logic [15:0] wl_en0;
  real         bl_pre_v0;

  logic        ready1, rvalid1, pre_en1, sae1, wd_en1;
  logic [7:0]  rdata1, bl_data1;
  logic [15:0] wl_en1;
  real         bl_pre_v1;

  int total = 0;
  int bad   = 0;

  sram_access_ctrl #(.T_PRE(2), .T_WL(2)) u_dut0 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .sense_in(sense_in), .ready(ready0), .rvalid(rvalid0), .rdata(rdata0),
    .pre_en(pre_en0), .bl_pre_v(bl_pre_v0), .wl_en(wl_en0), .sae(sae0),
    .wd_en(wd_en0), .bl_data(bl_data0)
  );

  sram_access_ctrl #(.T_PRE(1), .T_WL(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .sense_in(sense_in), .ready(ready1), .rvalid(rvalid1), .rdata(rdata1),
    .pre_en(pre_en1), .bl_pre_v(bl_pre_v1), .wl_en(wl_en1), .sae(sae1),
    .wd_en(wd_en1), .bl_data(bl_data1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_real(input string name, input real act, input real exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%f required=%f t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an access is a timeline indexed by the cycle
  // number since its accept edge (cycle 1 is the first cycle after it).
  bit       m_busy  [2];
  int       m_phase [2];
  bit       m_we    [2];
  bit [3:0] m_addr  [2];
  bit [7:0] m_wdata [2];
  bit [7:0] m_rdata [2];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i]  <= 1'b0;
        m_phase[i] <= 0;
        m_rdata[i] <= 8'h00;
      end else if (!m_busy[i]) begin
        if (req) begin
          m_busy[i]  <= 1'b1;
          m_phase[i] <= 1;
          m_we[i]    <= we;
          m_addr[i]  <= addr;
          m_wdata[i] <= wdata;
        end
      end else begin
        if (!m_we[i] && m_phase[i] == TPA[i] + TWA[i] + 1)
          m_rdata[i] <= sense_in;
        if (m_phase[i] == (m_we[i] ? TPA[i] + TWA[i] + 1 : TPA[i] + TWA[i] + 2))
          m_busy[i] <= 1'b0;
        else
          m_phase[i] <= m_phase[i] + 1;
      end
    end
  end

  task automatic check_inst(input int i, input logic a_ready, input logic a_rvalid,
                            input logic [7:0] a_rdata, input logic a_pre, input real a_v,
                            input logic [15:0] a_wl, input logic a_sae, input logic a_wd,
                            input logic [7:0] a_bld);
    int tp = TPA[i];
    int tw = TWA[i];
    int p  = m_phase[i];
    bit b  = m_busy[i];
    bit rd = !m_we[i];
    bit e_pre, e_wl, e_sae, e_wd, e_rv;
    logic [15:0] one = 16'h0001;
    logic [15:0] e_wl_vec;
    e_pre = b && p <= tp;
    e_wl  = b && p > tp && p <= tp + tw + (rd ? 1 : 0);
    e_sae = b && rd && p == tp + tw + 1;
    e_wd  = b && !rd && p > tp && p <= tp + tw;
    e_rv  = b && rd && p == tp + tw + 2;
    e_wl_vec = e_wl ? (one << m_addr[i]) : 16'h0000;
    chk($sformatf("m%0d_ready", i), a_ready, !b);
    chk($sformatf("m%0d_rvalid", i), a_rvalid, e_rv);
    chk($sformatf("m%0d_rdata", i), a_rdata, m_rdata[i]);
    chk($sformatf("m%0d_pre_en", i), a_pre, e_pre);
    chk_real($sformatf("m%0d_bl_pre_v", i), a_v, e_pre ? 1.5 : 0.0);
    chk($sformatf("m%0d_wl_en", i), a_wl, e_wl_vec);
    chk($sformatf("m%0d_sae", i), a_sae, e_sae);
    chk($sformatf("m%0d_wd_en", i), a_wd, e_wd);
    chk($sformatf("m%0d_bl_data", i), a_bld, e_wd ? m_wdata[i] : 8'h00);
    chk($sformatf("m%0d_excl_pre_wl", i), a_pre && (a_wl != 16'h0), 1'b0);
    chk($sformatf("m%0d_excl_sae_wd", i), a_sae && a_wd, 1'b0);
  endtask

  always @(negedge clk) begin
    check_inst(0, ready0, rvalid0, rdata0, pre_en0, bl_pre_v0, wl_en0, sae0, wd_en0, bl_data0);
    check_inst(1, ready1, rvalid1, rdata1, pre_en1, bl_pre_v1, wl_en1, sae1, wd_en1, bl_data1);
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready0 && ready1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_idle", ok, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; sense_in = '0;

    // Reset state
    @(negedge clk);
    chk("rst_ready", ready0, 1'b1);
    chk("rst_rdata", rdata0, 8'h00);
    chk("rst_wl_en", wl_en0, 16'h0000);
    chk_real("rst_bl_pre_v", bl_pre_v0, 0.0);
    @(posedge clk); @(posedge clk); #2 rst = 1'b0;

    // Read addr 5, sense A5
    @(posedge clk); #2 req = 1'b1; we = 1'b0; addr = 4'd5; sense_in = 8'hA5;
    @(posedge clk); #2 req = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n <= 2) begin
        chk("rd_pre_en", pre_en0, 1'b1);
        chk_real("rd_bl_pre_v", bl_pre_v0, 1.5);
      end
      if (n >= 3 && n <= 5) chk("rd_wl_en", wl_en0, 16'h0020);
      if (n == 5) chk("rd_sae", sae0, 1'b1);
      if (n == 6) begin
        chk("rd_rvalid", rvalid0, 1'b1);
        chk("rd_rdata", rdata0, 8'hA5);
        chk("rd_ready_recover", ready0, 1'b0);
      end
      if (n == 7) chk("rd_ready", ready0, 1'b1);
      if (n == 4) chk("rd1_rvalid", rvalid1, 1'b1);
      if (n == 5) chk("rd1_ready", ready1, 1'b1);
    end

    // Write addr 15, data 3C
    @(posedge clk); #2 req = 1'b1; we = 1'b1; addr = 4'd15; wdata = 8'h3C;
    @(posedge clk); #2 req = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      chk("wr_no_rvalid", rvalid0, 1'b0);
      if (n == 3 || n == 4) begin
        chk("wr_wl_en", wl_en0, 16'h8000);
        chk("wr_wd_en", wd_en0, 1'b1);
        chk("wr_bl_data", bl_data0, 8'h3C);
      end
      if (n == 5) chk("wr_ready_recover", ready0, 1'b0);
      if (n == 6) chk("wr_ready", ready0, 1'b1);
      if (n == 2) chk("wr1_bl_data", bl_data1, 8'h3C);
      if (n == 4) chk("wr1_ready", ready1, 1'b1);
    end

    // req held high: second access only after RECOVER
    @(posedge clk); #2 req = 1'b1; we = 1'b0; addr = 4'd3; sense_in = 8'h5A;
    @(posedge clk);
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (n == 6) begin
        chk("hold_ready_recover", ready0, 1'b0);
        chk("hold_rdata", rdata0, 8'h5A);
      end
      if (n == 7) chk("hold_ready", ready0, 1'b1);
      if (n == 8) begin
        chk("hold_second_pre", pre_en0, 1'b1);
        chk("hold_second_busy", ready0, 1'b0);
      end
    end
    @(posedge clk); #2 req = 1'b0;
    wait_idle();

    // Reset pulse during WL_ON
    @(posedge clk); #2 req = 1'b1; we = 1'b0; addr = 4'd9; sense_in = 8'hC3;
    @(posedge clk); #2 req = 1'b0;
    @(posedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("abort_ready", ready0, 1'b1);
    chk("abort_wl_en", wl_en0, 16'h0000);
    chk("abort_rvalid", rvalid0, 1'b0);
    chk("abort_rdata", rdata0, 8'h00);
    chk("abort_pre_en", pre_en0, 1'b0);
    @(posedge clk); #2 rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("abort_no_rvalid", rvalid0, 1'b0);
    end

    // Randomised traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      rst      = ($urandom_range(0, 299) == 0);
      req      = ($urandom_range(0, 2) != 0);
      we       = $urandom_range(0, 1);
      addr     = 4'($urandom_range(0, 15));
      wdata    = 8'($urandom_range(0, 255));
      sense_in = 8'($urandom_range(0, 255));
    end
    @(posedge clk); #2 rst = 1'b0; req = 1'b0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
